// File: rtl/touch_pkg.sv
// Shared constants for the ADS7846-style touch-panel scan controller.
package touch_pkg;

  localparam logic [7:0] CMD_X_DEFAULT = 8'h90;
  localparam logic [7:0] CMD_Y_DEFAULT = 8'hD0;

  // Frame edge numbering is 1-based, counted on DCLK rising edges
  localparam logic [4:0] CMD_BITS    = 5'd8;
  localparam logic [4:0] BUSY_EDGE   = 5'd9;
  localparam logic [4:0] DATA_FIRST  = BUSY_EDGE + 5'd1;
  localparam logic [4:0] DATA_LAST   = 5'd21;
  localparam logic [4:0] FRAME_EDGES = 5'd24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CSLOW = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/touch_scan_ctrl_if.sv
// Panel-side serial link plus the DCLK divider enable/output.
interface touch_scan_ctrl_if;
  logic dclk_en;
  logic tp_cs_n;
  logic tp_din;
  logic tp_dout;
  logic tp_busy;
  logic tp_penirq_n;
  logic tp_dclk;

  modport master (
    output dclk_en, tp_cs_n, tp_din,
    input  tp_dout, tp_busy, tp_penirq_n, tp_dclk
  );

  modport slave (
    input  dclk_en, tp_cs_n, tp_din,
    output tp_dout, tp_busy, tp_penirq_n, tp_dclk
  );
endinterface

// File: rtl/touch_spi_frame.sv
// One 24-edge conversion frame: DCLK edge detect, edge counter, command
// shifter on DIN and 12-bit result shifter on DOUT.
module touch_spi_frame
  import touch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  cmd,
  input  logic        tp_dclk,
  input  logic        tp_dout,
  output logic        din,
  output logic        done,
  output logic [11:0] data
);

  logic       dclk_q;
  logic       active;
  logic [4:0] edge_cnt;
  logic [7:0] cmd_sr;
  logic       rise;
  logic       fall;

  assign rise = tp_dclk & ~dclk_q;
  assign fall = ~tp_dclk & dclk_q;
  assign done = active & rise & (edge_cnt == FRAME_EDGES - 5'd1);
  assign din  = cmd_sr[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_q   <= 1'b0;
      active   <= 1'b0;
      edge_cnt <= '0;
      cmd_sr   <= '0;
      data     <= '0;
    end else begin
      dclk_q <= tp_dclk;
      if (load) begin
        active   <= 1'b1;
        edge_cnt <= '0;
        cmd_sr   <= cmd;
      end else if (active) begin
        if (rise) begin
          if (done) begin
            edge_cnt <= '0;
            active   <= 1'b0;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
          // edge_cnt still holds the previous count, so this rise is edge_cnt+1
          if (edge_cnt >= DATA_FIRST - 5'd1 && edge_cnt <= DATA_LAST - 5'd1)
            data <= {data[10:0], tp_dout};
        end
        // Shifting zeros in leaves DIN low once the command byte is out
        if (fall && edge_cnt >= 5'd1 && edge_cnt <= CMD_BITS)
          cmd_sr <= {cmd_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/touch_scan_ctrl.sv
// Sequences one X then one Y conversion on the touch panel and publishes
// the 12-bit results with a one-cycle valid pulse.
module touch_scan_ctrl
  import touch_pkg::*;
#(
  parameter logic [7:0]  CMD_X      = CMD_X_DEFAULT,
  parameter logic [7:0]  CMD_Y      = CMD_Y_DEFAULT,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter bit          AUTO_SCAN  = 1'b1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  touch_scan_ctrl_if.master  tp,
  output logic [11:0]        x_out,
  output logic [11:0]        y_out,
  output logic               valid,
  output logic               scan_busy,
  output logic               pen_down
);

  localparam logic [15:0] CS_LAST  = (CS_SETUP == 0)   ? 16'd0 : 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  logic [2:0]  state;
  logic [15:0] cs_cnt;
  logic [15:0] gap_cnt;
  logic        second;
  logic [11:0] x_hold;
  logic        frame_load;
  logic        frame_done;
  logic [11:0] frame_data;
  logic        cs_done;

  assign cs_done    = (cs_cnt >= CS_LAST);
  assign frame_load = (state == ST_CSLOW) && cs_done;
  assign scan_busy  = (state != ST_IDLE) && (state != ST_GAP);

  touch_spi_frame u_frame (
    .clk     (clk),
    .rst     (rst),
    .load    (frame_load),
    .cmd     (second ? CMD_Y : CMD_X),
    .tp_dclk (tp.tp_dclk),
    .tp_dout (tp.tp_dout),
    .din     (tp.tp_din),
    .done    (frame_done),
    .data    (frame_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tp.dclk_en <= 1'b0;
      tp.tp_cs_n <= 1'b1;
      x_out      <= '0;
      y_out      <= '0;
      x_hold     <= '0;
      valid      <= 1'b0;
      pen_down   <= 1'b0;
      cs_cnt     <= '0;
      gap_cnt    <= '0;
      second     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          pen_down <= ~tp.tp_penirq_n;
          if (start || (AUTO_SCAN && pen_down)) begin
            state      <= ST_CSLOW;
            tp.tp_cs_n <= 1'b0;
            cs_cnt     <= '0;
            second     <= 1'b0;
          end
        end
        ST_CSLOW: begin
          if (cs_done) begin
            state      <= ST_XFER;
            tp.dclk_en <= 1'b1;
          end else begin
            cs_cnt <= cs_cnt + 16'd1;
          end
        end
        ST_XFER: begin
          if (frame_done) begin
            tp.dclk_en <= 1'b0;
            cs_cnt     <= '0;
            // CS stays low; the second CSLOW pass doubles as the inter-frame gap
            if (!second) begin
              x_hold <= frame_data;
              second <= 1'b1;
              state  <= ST_CSLOW;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          x_out      <= x_hold;
          y_out      <= frame_data;
          valid      <= 1'b1;
          tp.tp_cs_n <= 1'b1;
          gap_cnt    <= '0;
          state      <= ST_GAP;
        end
        ST_GAP: begin
          pen_down <= ~tp.tp_penirq_n;
          if (gap_cnt >= GAP_LAST)
            state <= ST_IDLE;
          else if (gap_cnt != '1)
            gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
